// File: rtl/isp_line_sched.sv
// ============================================================================
// Module   : isp_line_sched
// Brief    : Debayer line scheduler. It gates line-buffer write strobes, primes
//            the buffers, and issues fixed-length read bursts against line credits.
// Options  : ISP_LINE_LEN_CHECK_EN enables the per-line entry-count check (err_len).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isp_line_sched #(
  parameter int LINE_LENGTH = 640,
  parameter int PRIME_LINES = 2,
  parameter int MAX_LINES   = 4,
  parameter int LCNT_W      = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           isp_en,
  input  logic                           csi_frame_start,
  input  logic                           csi_frame_end,
  input  logic                           csi_line_valid,
  input  logic                           line_req,
  input  logic                           err_clr,
  output logic                           isp_data_valid,
  output logic                           isp_rgb_valid,
  output logic [LCNT_W-1:0]              line_cnt,
  output logic [$clog2(MAX_LINES+1)-1:0] lines_avail,
  output logic                           frame_active,
  output logic                           err_ovf,
  output logic                           err_udr,
  output logic                           err_sync,
  output logic                           err_len
);

  localparam int c_LA_W = $clog2(MAX_LINES + 1);
  localparam int c_BC_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [c_LA_W-1:0] c_MAX_AVAIL   = c_LA_W'(MAX_LINES);
  localparam logic [c_LA_W-1:0] c_PRIME_AVAIL = c_LA_W'(PRIME_LINES);
  localparam logic [LCNT_W-1:0] c_PRIME_LAST  = LCNT_W'(PRIME_LINES - 1);
  localparam logic [c_BC_W-1:0] c_BURST_LAST  = c_BC_W'(LINE_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_FS = 3'd1,
    S_PRIME   = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_dv_d;
  logic                r_burst;
  logic [c_BC_W-1:0]   r_bcnt;
  logic                r_err_ovf;
  logic                r_err_udr;
  logic                r_err_sync;

  logic w_wr_state;
  logic w_rd_state;
  logic w_in_frame;
  logic w_gated;
  logic w_line_end;
  logic w_req_free;
  logic w_burst_start;
  logic w_udr;
  logic w_burst_last;
  logic w_fs_sync;
  logic w_fe_sync;
  logic w_avail_inc;
  logic w_ovf;

  assign w_wr_state    = (r_state == S_PRIME) || (r_state == S_RUN);
  assign w_rd_state    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_in_frame    = w_wr_state || (r_state == S_DRAIN);
  assign w_gated       = csi_line_valid & w_wr_state;
  // A line ends on the falling edge of the gated strobe, one cycle after its last entry.
  assign w_line_end    = r_dv_d & ~w_gated;
  assign w_req_free    = w_rd_state & line_req & ~r_burst;
  assign w_burst_start = w_req_free & (lines_avail != '0);
  assign w_udr         = w_req_free & (lines_avail == '0);
  assign w_burst_last  = r_burst & (r_bcnt == c_BURST_LAST);
  assign w_fs_sync     = csi_frame_start & w_in_frame;
  assign w_fe_sync     = csi_frame_end & ((r_state == S_WAIT_FS) || (r_state == S_PRIME));
  assign w_avail_inc   = w_line_end & (r_state == S_RUN);
  // A simultaneous burst start consumes the incoming credit, so that case is not an overflow.
  assign w_ovf         = w_avail_inc & ~w_burst_start & (lines_avail == c_MAX_AVAIL);

  assign isp_data_valid = w_gated;
  assign isp_rgb_valid  = r_burst;
  assign frame_active   = w_in_frame;
  assign err_ovf        = r_err_ovf;
  assign err_udr        = r_err_udr;
  assign err_sync       = r_err_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dv_d      <= 1'b0;
      r_burst     <= 1'b0;
      r_bcnt      <= '0;
      line_cnt    <= '0;
      lines_avail <= '0;
    end else begin
      r_dv_d <= w_gated;

      if (w_fs_sync) begin
        r_burst <= 1'b0;
        r_bcnt  <= '0;
      end else if (w_burst_start) begin
        r_burst <= 1'b1;
        r_bcnt  <= '0;
      end else if (r_burst) begin
        r_burst <= ~w_burst_last;
        r_bcnt  <= w_burst_last ? '0 : r_bcnt + 1'b1;
      end

      if (w_line_end) begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (w_avail_inc && !w_burst_start) begin
        if (lines_avail != c_MAX_AVAIL) begin
          lines_avail <= lines_avail + 1'b1;
        end
      end else if (w_burst_start && !w_avail_inc) begin
        lines_avail <= lines_avail - 1'b1;
      end

      // Frame-level transitions; these assignments override the counter updates above.
      case (r_state)
        S_IDLE: begin
          if (isp_en) begin
            r_state <= S_WAIT_FS;
          end
        end
        S_WAIT_FS: begin
          if (csi_frame_start) begin
            r_state     <= S_PRIME;
            line_cnt    <= '0;
            lines_avail <= '0;
          end else if (!csi_frame_end && !isp_en) begin
            r_state <= S_IDLE;
          end
        end
        S_PRIME: begin
          if (csi_frame_start) begin
            line_cnt    <= '0;
            lines_avail <= '0;
          end else if (csi_frame_end) begin
            r_state <= S_WAIT_FS;
          end else if (w_line_end && (line_cnt >= c_PRIME_LAST)) begin
            r_state     <= S_RUN;
            lines_avail <= c_PRIME_AVAIL;
          end
        end
        S_RUN: begin
          if (csi_frame_start) begin
            r_state     <= S_PRIME;
            line_cnt    <= '0;
            lines_avail <= '0;
          end else if (csi_frame_end) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (csi_frame_start) begin
            r_state     <= S_PRIME;
            line_cnt    <= '0;
            lines_avail <= '0;
          end else if ((lines_avail == '0) && !r_burst) begin
            r_state <= isp_en ? S_WAIT_FS : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_ovf  <= 1'b0;
      r_err_udr  <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      r_err_ovf  <= (r_err_ovf  & ~err_clr) | w_ovf;
      r_err_udr  <= (r_err_udr  & ~err_clr) | w_udr;
      r_err_sync <= (r_err_sync & ~err_clr) | w_fs_sync | w_fe_sync;
    end
  end

`ifdef ISP_LINE_LEN_CHECK_EN
  localparam int c_EC_W = $clog2(LINE_LENGTH + 2);

  logic [c_EC_W-1:0] r_ecnt;
  logic              r_err_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ecnt    <= '0;
      r_err_len <= 1'b0;
    end else begin
      if (w_gated) begin
        if (r_ecnt != '1) begin
          r_ecnt <= r_ecnt + 1'b1;
        end
      end else begin
        r_ecnt <= '0;
      end
      r_err_len <= (r_err_len & ~err_clr) |
                   (w_line_end & (r_ecnt != c_EC_W'(LINE_LENGTH)));
    end
  end

  assign err_len = r_err_len;
`else
  assign err_len = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_isp_line_sched.sv
// ============================================================================
// Module   : tb_isp_line_sched
// Brief    : Directed self-checking bench for isp_line_sched (8-entry lines).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isp_line_sched;

  localparam int LL = 8;
  localparam int PL = 2;
  localparam int ML = 4;
  localparam int LW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, isp_en, fs, fe, lv, req, clr;
  logic dv, rgb, fa, eo, eu, es, el;
  logic [LW-1:0] lcnt;
  logic [2:0]    avail;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  logic exp_len;

  isp_line_sched #(
    .LINE_LENGTH (LL),
    .PRIME_LINES (PL),
    .MAX_LINES   (ML),
    .LCNT_W      (LW)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .isp_en          (isp_en),
    .csi_frame_start (fs),
    .csi_frame_end   (fe),
    .csi_line_valid  (lv),
    .line_req        (req),
    .err_clr         (clr),
    .isp_data_valid  (dv),
    .isp_rgb_valid   (rgb),
    .line_cnt        (lcnt),
    .lines_avail     (avail),
    .frame_active    (fa),
    .err_ovf         (eo),
    .err_udr         (eu),
    .err_sync        (es),
    .err_len         (el)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line of n entries; optional err_clr / line_req on the line-end cycle.
  task automatic send_line(input int n, input logic with_clr, input logic with_req);
    lv = 1'b1;
    repeat (n) tick();
    lv  = 1'b0;
    clr = with_clr;
    req = with_req;
    tick();
    clr = 1'b0;
    req = 1'b0;
  endtask

  task automatic do_burst();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (LL) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef ISP_LINE_LEN_CHECK_EN
    exp_len = 1'b1;
`else
    exp_len = 1'b0;
`endif
    rst_n = 1'b0; isp_en = 1'b0; fs = 1'b0; fe = 1'b0;
    lv = 1'b0; req = 1'b0; clr = 1'b0;
    repeat (3) tick();
    check("rst_dv", dv, 0);
    check("rst_rgb", rgb, 0);
    check("rst_lcnt", lcnt, 0);
    check("rst_avail", avail, 0);
    check("rst_fa", fa, 0);
    check("rst_errs", {eo, eu, es, el}, 0);

    // Enable, then lines outside a frame are dropped
    rst_n = 1'b1; isp_en = 1'b1;
    tick();
    lv = 1'b1; #1;
    check("wait_fs_dv_gated", dv, 0);
    lv = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0;
    check("prime_fa", fa, 1);

    // Priming: two lines -> RUN with two credits, no readout yet
    send_line(LL, 1'b0, 1'b0);
    check("prime_lcnt1", lcnt, 1);
    check("prime_avail0", avail, 0);
    send_line(LL, 1'b0, 1'b0);
    check("run_lcnt2", lcnt, 2);
    check("run_avail2", avail, 2);
    check("run_rgb_idle", rgb, 0);
    check("len_ok", el, 0);

    // Burst of exactly LL cycles; a request mid-burst is ignored
    req = 1'b1; tick(); req = 1'b0;
    check("burst_avail1", avail, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (rgb) cnt++;
      if (i < LL) check("burst_high", rgb, 1);
      req = (i == 3);
      tick();
      req = 1'b0;
    end
    check("burst_len", cnt, LL);
    check("burst_avail_after", avail, 1);
    check("burst_no_udr", eu, 0);

    // Credits to ceiling, then overflow saturates
    repeat (3) send_line(LL, 1'b0, 1'b0);
    check("avail_full", avail, 4);
    check("no_ovf_yet", eo, 0);
    send_line(LL, 1'b0, 1'b0);
    check("ovf_sat", avail, 4);
    check("ovf_set", eo, 1);
    pulse_clr();
    check("ovf_clr", eo, 0);
    send_line(LL, 1'b1, 1'b0);
    check("ovf_set_dominant", eo, 1);
    pulse_clr();
    check("ovf_clr2", eo, 0);

    // Drain all credits, then an underrun
    repeat (4) do_burst();
    check("drained", avail, 0);
    req = 1'b1; tick(); req = 1'b0;
    check("udr_no_burst", rgb, 0);
    check("udr_set", eu, 1);
    check("udr_avail", avail, 0);
    pulse_clr();
    check("udr_clr", eu, 0);

    // Line end and burst start on the same edge
    send_line(LL, 1'b0, 1'b0);
    check("one_credit", avail, 1);
    send_line(LL, 1'b0, 1'b1);
    check("same_cycle_avail", avail, 1);
    check("same_cycle_rgb", rgb, 1);
    repeat (LL) tick();
    check("same_cycle_burst_end", rgb, 0);

    // Frame start mid-burst aborts and re-primes
    req = 1'b1; tick(); req = 1'b0;
    check("abort_burst_on", rgb, 1);
    repeat (2) tick();
    fs = 1'b1; tick(); fs = 1'b0;
    check("abort_rgb", rgb, 0);
    check("abort_sync", es, 1);
    check("abort_lcnt", lcnt, 0);
    check("abort_avail", avail, 0);
    check("abort_fa", fa, 1);
    send_line(LL, 1'b0, 1'b0);
    check("reprime_avail0", avail, 0);
    send_line(LL, 1'b0, 1'b0);
    check("reprime_avail2", avail, 2);

    // Frame end, drain two lines, back to WAIT_FS
    fe = 1'b1; tick(); fe = 1'b0;
    check("drain_fa", fa, 1);
    do_burst();
    check("drain_avail1", avail, 1);
    do_burst();
    check("drain_avail0", avail, 0);
    check("drain_still", fa, 1);
    tick();
    check("drain_exit_fa", fa, 0);
    fs = 1'b1; tick(); fs = 1'b0;
    check("wait_fs_to_prime", fa, 1);

    // Short line and frame-end while priming
    pulse_clr();
    check("sync_clr", es, 0);
    check("len_before_short", el, 0);
    send_line(LL - 1, 1'b0, 1'b0);
    check("short_lcnt", lcnt, 1);
    check("short_len", el, exp_len);
    fe = 1'b1; tick(); fe = 1'b0;
    check("fe_prime_sync", es, 1);
    check("fe_prime_fa", fa, 0);

    // Reset mid-frame and mid-burst
    pulse_clr();
    fs = 1'b1; tick(); fs = 1'b0;
    send_line(LL, 1'b0, 1'b0);
    send_line(LL, 1'b0, 1'b0);
    req = 1'b1; tick(); req = 1'b0;
    lv = 1'b1; #1;
    check("run_dv_pass", dv, 1);
    check("pre_rst_rgb", rgb, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_dv", dv, 0);
    check("mrst_rgb", rgb, 0);
    check("mrst_lcnt", lcnt, 0);
    check("mrst_avail", avail, 0);
    check("mrst_fa", fa, 0);
    check("mrst_errs", {eo, eu, es, el}, 0);
    lv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
